// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, response and memory bus bundle for the load/store unit
//
// Purpose: groups every handshake and bus signal of the load/store unit so the
// execute stage, writeback and data memory connect through a single port.
//
// Signals:
//   req_valid/req_ready    execute stage presents a memory op / unit accepts it
//   req_is_store           1 = store, 0 = load
//   req_addr[31:0]         byte address
//   req_wdata[31:0]        store data (rs2)
//   req_funct3[2:0]        [1:0] access size, [2] unsigned load
//   req_rd[4:0]            destination register
//   resp_valid/resp_ready  response handshake towards writeback
//   resp_rdata[31:0]       extended load data
//   resp_rd[4:0]           destination register of the response
//   resp_err               misaligned or illegal op, no memory access made
//   mem_req/mem_we         memory request and write enable
//   mem_addr[31:0]         word-aligned memory address
//   mem_wdata[31:0]        lane-replicated store data
//   mem_be[3:0]            byte enables
//   mem_ack/mem_rdata      completion strobe and read word
//
// Modports: slave is the load/store unit, master is its environment.

interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_is_store, req_addr, req_wdata, req_funct3, req_rd,
        input  resp_ready, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output req_valid, req_is_store, req_addr, req_wdata, req_funct3, req_rd,
        output resp_ready, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_rd, resp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with alignment checks
//
// Purpose: accepts one load or store at a time from the execute stage, checks
// size/alignment, performs one word access on the data memory bus, and returns
// the extended load data (or an error) to writeback. Every output is a register.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   bus   load_store_unit_if.slave: request, response and memory bus signals
//
// State flow: IDLE -> MEM -> RESP -> IDLE for legal ops, IDLE -> RESP -> IDLE
// for illegal or misaligned ops (memory is never touched for those).

module load_store_unit (
    input  logic                  clk,
    input  logic                  rst,
    load_store_unit_if.slave      bus
);

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } load_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MEM  = 2'b01,
        RESP = 2'b10
    } state_e;

    state_e      state;

    // Request fields that are still needed after the memory access
    logic [1:0]  cap_size;
    logic        cap_uns;
    logic [1:0]  cap_off;
    logic [4:0]  cap_rd;
    logic        cap_store;

    logic        req_illegal;
    logic        req_misaligned;
    logic [3:0]  store_be;
    logic [31:0] store_data;
    logic [31:0] rd_lane;
    logic [31:0] load_ext;

    // Decode of the incoming request, used only in the acceptance cycle
    always_comb begin
        req_illegal    = 1'b0;
        req_misaligned = 1'b0;
        store_be       = 4'b1111;
        store_data     = bus.req_wdata;

        if (bus.req_funct3[1:0] == 2'b11)
            req_illegal = 1'b1;
        if (bus.req_is_store && bus.req_funct3[2])
            req_illegal = 1'b1;
        if (!bus.req_is_store && bus.req_funct3 == 3'b110)
            req_illegal = 1'b1;

        case (bus.req_funct3[1:0])
            LS_BYTE: begin
                store_be   = 4'b0001 << bus.req_addr[1:0];
                store_data = {4{bus.req_wdata[7:0]}};
            end
            LS_HALF: begin
                req_misaligned = bus.req_addr[0];
                store_be       = 4'b0011 << bus.req_addr[1:0];
                store_data     = {2{bus.req_wdata[15:0]}};
            end
            LS_WORD: begin
                req_misaligned = (bus.req_addr[1:0] != 2'b00);
            end
            default: begin
                store_be   = 4'b1111;
                store_data = bus.req_wdata;
            end
        endcase
    end

    // Lane select and extension of the returned word; meaningful only while
    // mem_ack is high in MEM, which is the only time it is registered.
    always_comb begin
        rd_lane  = bus.mem_rdata >> {cap_off, 3'b000};
        load_ext = rd_lane;
        case (cap_size)
            LS_BYTE: load_ext = cap_uns ? {24'h0, rd_lane[7:0]}
                                        : {{24{rd_lane[7]}}, rd_lane[7:0]};
            LS_HALF: load_ext = cap_uns ? {16'h0, rd_lane[15:0]}
                                        : {{16{rd_lane[15]}}, rd_lane[15:0]};
            default: load_ext = rd_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cap_size       <= 2'b00;
            cap_uns        <= 1'b0;
            cap_off        <= 2'b00;
            cap_rd         <= 5'd0;
            cap_store      <= 1'b0;
            bus.req_ready  <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.resp_rd    <= 5'd0;
            bus.resp_err   <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= 32'h0;
            bus.mem_wdata  <= 32'h0;
            bus.mem_be     <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready rises the first cycle out of reset and stays up
                    // until an op is taken.
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        cap_size      <= bus.req_funct3[1:0];
                        cap_uns       <= bus.req_funct3[2];
                        cap_off       <= bus.req_addr[1:0];
                        cap_rd        <= bus.req_rd;
                        cap_store     <= bus.req_is_store;
                        if (req_illegal || req_misaligned) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= 32'h0;
                            bus.resp_rd    <= 5'd0;
                        end else begin
                            state         <= MEM;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.req_is_store;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            // Loads read the full word; the lane is picked on return.
                            bus.mem_be    <= bus.req_is_store ? store_be : 4'b1111;
                            bus.mem_wdata <= bus.req_is_store ? store_data : 32'h0;
                        end
                    end
                end

                MEM: begin
                    // Bus outputs are left untouched until the ack is seen.
                    if (bus.mem_ack) begin
                        state          <= RESP;
                        bus.mem_req    <= 1'b0;
                        bus.mem_we     <= 1'b0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        if (cap_store) begin
                            bus.resp_rdata <= 32'h0;
                            bus.resp_rd    <= 5'd0;
                        end else begin
                            bus.resp_rdata <= load_ext;
                            bus.resp_rd    <= cap_rd;
                        end
                    end
                end

                RESP: begin
                    // req_ready stays low during the handshake cycle so a new op
                    // can only be taken once back in IDLE.
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.req_ready  <= 1'b1;
                        bus.resp_valid <= 1'b0;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= 32'h0;
                        bus.resp_rd    <= 5'd0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit

module tb_load_store_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one op for exactly one cycle (cycle N); returns at the negedge of N+1.
    task automatic issue(input logic st, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input logic [4:0] rd);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        bus.req_funct3   = f3;
        bus.req_rd       = rd;
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_funct3   = 3'b000;
        bus.req_rd       = 5'd0;
    endtask

    // One-cycle memory ack with read data; returns one negedge later.
    task automatic ack(input logic [31:0] rdata);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    task automatic handshake();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_req, bus.mem_we} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000", {bus.req_ready, bus.resp_valid,
                     bus.resp_err, bus.mem_req, bus.mem_we});
        end
        checks++;
        if ({bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.resp_rdata, bus.resp_rd} !== 105'h0) begin
            failures++;
            $display("FAIL reset_data: be=%b addr=%h wdata=%h rdata=%h rd=%0d expected all zero",
                     bus.mem_be, bus.mem_addr, bus.mem_wdata, bus.resp_rdata, bus.resp_rd);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_lb();
        issue(1'b0, 32'h0000_1003, 32'h0, 3'b000, 5'd5);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.resp_valid} !== 3'b100 || bus.mem_addr !== 32'h0000_1000) begin
            failures++;
            $display("FAIL lb_mem: req/we/rv=%b addr=%h expected 100 addr=00001000",
                     {bus.mem_req, bus.mem_we, bus.resp_valid}, bus.mem_addr);
        end
        ack(32'h80FF_1234);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hFFFF_FF80 || bus.resp_rd !== 5'd5 ||
            bus.resp_err !== 1'b0 || bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL lb_resp: rv=%b rdata=%h rd=%0d err=%b mreq=%b expected 1 ffffff80 5 0 0",
                     bus.resp_valid, bus.resp_rdata, bus.resp_rd, bus.resp_err, bus.mem_req);
        end
        handshake();
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL lb_done: rv=%b ready=%b expected 0 1", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_half_loads();
        for (int i = 0; i < 2; i++) begin
            logic [2:0]  f3;
            logic [31:0] exp;
            f3  = (i == 0) ? 3'b101 : 3'b001;
            exp = (i == 0) ? 32'h0000_BEEF : 32'hFFFF_BEEF;
            issue(1'b0, 32'h0000_2002, 32'h0, f3, 5'd12);
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_2000) begin
                failures++;
                $display("FAIL half_mem[%0d]: req=%b addr=%h expected 1 00002000", i, bus.mem_req, bus.mem_addr);
            end
            ack(32'hBEEF_0000);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp || bus.resp_rd !== 5'd12) begin
                failures++;
                $display("FAIL half_resp[%0d]: rv=%b rdata=%h rd=%0d expected 1 %h 12",
                         i, bus.resp_valid, bus.resp_rdata, bus.resp_rd, exp);
            end
            handshake();
        end
    endtask

    task automatic test_stores();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a, wd, exp_wd, exp_addr;
            logic [2:0]  f3;
            logic [3:0]  exp_be;
            case (i)
                0: begin a = 32'h3001; wd = 32'h1234_56AB; f3 = 3'b000; exp_be = 4'b0010;
                         exp_wd = 32'hABAB_ABAB; exp_addr = 32'h3000; end
                1: begin a = 32'h5002; wd = 32'h0000_CAFE; f3 = 3'b001; exp_be = 4'b1100;
                         exp_wd = 32'hCAFE_CAFE; exp_addr = 32'h5000; end
                default: begin a = 32'h5000; wd = 32'hDEAD_BEEF; f3 = 3'b010; exp_be = 4'b1111;
                         exp_wd = 32'hDEAD_BEEF; exp_addr = 32'h5000; end
            endcase
            issue(1'b1, a, wd, f3, 5'd7);
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== exp_be ||
                bus.mem_wdata !== exp_wd || bus.mem_addr !== exp_addr) begin
                failures++;
                $display("FAIL store_mem[%0d]: req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 %b %h %h",
                         i, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr,
                         exp_be, exp_wd, exp_addr);
            end
            ack(32'hFFFF_FFFF);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rd !== 5'd0 || bus.resp_rdata !== 32'h0 ||
                bus.resp_err !== 1'b0) begin
                failures++;
                $display("FAIL store_resp[%0d]: rv=%b rd=%0d rdata=%h err=%b expected 1 0 0 0",
                         i, bus.resp_valid, bus.resp_rd, bus.resp_rdata, bus.resp_err);
            end
            handshake();
        end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 5; i++) begin
            logic        st;
            logic [31:0] a;
            logic [2:0]  f3;
            case (i)
                0: begin st = 1'b0; a = 32'h4002; f3 = 3'b010; end
                1: begin st = 1'b0; a = 32'h4000; f3 = 3'b011; end
                2: begin st = 1'b1; a = 32'h4000; f3 = 3'b100; end
                3: begin st = 1'b0; a = 32'h4000; f3 = 3'b110; end
                default: begin st = 1'b0; a = 32'h4001; f3 = 3'b001; end
            endcase
            issue(st, a, 32'h5555_5555, f3, 5'd9);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0 ||
                bus.resp_rd !== 5'd0 || bus.mem_req !== 1'b0) begin
                failures++;
                $display("FAIL error_resp[%0d]: rv=%b err=%b rdata=%h rd=%0d mreq=%b expected 1 1 0 0 0",
                         i, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.resp_rd, bus.mem_req);
            end
            handshake();
        end
    endtask

    task automatic test_delay_and_stall();
        issue(1'b0, 32'h0000_6000, 32'h0, 3'b010, 5'd3);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({bus.mem_req, bus.mem_we, bus.req_ready, bus.resp_valid} !== 4'b1000 ||
                bus.mem_addr !== 32'h0000_6000 || bus.mem_be !== 4'b1111) begin
                failures++;
                $display("FAIL delay_mem[%0d]: req/we/ready/rv=%b addr=%h be=%b expected 1000 00006000 1111",
                         c, {bus.mem_req, bus.mem_we, bus.req_ready, bus.resp_valid}, bus.mem_addr, bus.mem_be);
            end
            @(negedge clk);
        end
        ack(32'h1122_3344);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1122_3344 || bus.resp_rd !== 5'd3 ||
                bus.req_ready !== 1'b0 || bus.mem_req !== 1'b0) begin
                failures++;
                $display("FAIL delay_resp[%0d]: rv=%b rdata=%h rd=%0d ready=%b mreq=%b expected 1 11223344 3 0 0",
                         c, bus.resp_valid, bus.resp_rdata, bus.resp_rd, bus.req_ready, bus.mem_req);
            end
            @(negedge clk);
        end
        handshake();
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL delay_done: ready=%b rv=%b expected 1 0", bus.req_ready, bus.resp_valid);
        end
    endtask

    task automatic test_back_to_back();
        // Error op accepted in N, response handshaken in N+1, next op accepted in N+2
        issue(1'b0, 32'h0000_0002, 32'h0, 3'b010, 5'd1);
        checks++;
        if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_err_resp: ready=%b rv=%b expected 0 1", bus.req_ready, bus.resp_valid);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_err_spacing: ready=%b rv=%b expected 1 0", bus.req_ready, bus.resp_valid);
        end
        // Legal LBU accepted in this cycle, ack in the first mem_req cycle
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_addr     = 32'h0000_8001;
        bus.req_funct3   = 3'b100;
        bus.req_rd       = 5'd2;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_legal_mem: mreq=%b ready=%b expected 1 0", bus.mem_req, bus.req_ready);
        end
        ack(32'h0000_9A00);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0000_009A || bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_legal_resp: rv=%b rdata=%h ready=%b expected 1 0000009a 0",
                     bus.resp_valid, bus.resp_rdata, bus.req_ready);
        end
        handshake();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_legal_spacing: ready=%b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        issue(1'b0, 32'h0000_7000, 32'h0, 3'b010, 5'd4);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_mem: mreq=%b expected 1", bus.mem_req);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_in_reset: mreq=%b ready=%b rv=%b expected 0 0 0",
                     bus.mem_req, bus.req_ready, bus.resp_valid);
        end
        rst = 1'b0;
        ack(32'hAAAA_AAAA);
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_late_ack: rv=%b ready=%b mreq=%b expected 0 1 0",
                     bus.resp_valid, bus.req_ready, bus.mem_req);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_no_resp: rv=%b expected 0", bus.resp_valid);
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_funct3   = 3'b000;
        bus.req_rd       = 5'd0;
        bus.resp_ready   = 1'b0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = 32'h0;

        test_reset();
        test_lb();
        test_half_loads();
        test_stores();
        test_errors();
        test_delay_and_stall();
        test_back_to_back();
        test_reset_mid_op();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Port: clk  in  1  clock.
REQ-003 Port: rst  in  1  synchronous active-high reset.
REQ-004 Port: req_valid  in  1  execute stage presents a memory op.
REQ-005 Port: req_ready  out  1  block can accept an op.
REQ-006 Port: req_is_store  in  1  1 = store, 0 = load.
REQ-007 Port: req_addr  in  32  byte address from ALU.
REQ-008 Port: req_wdata  in  32  store data (rs2).
REQ-009 Port: req_funct3  in  3  [1:0] size per load_size_e (BYTE 00, HALF_WORD 01, WORD 10); [2] = unsigned (LBU/LHU).
REQ-010 Port: req_rd  in  5  destination register.
REQ-011 Port: resp_valid / resp_ready  out / in  1 / 1  response handshake to writeback.
REQ-012 Port: resp_rdata  out  32  extended load data (0 for stores and errors).
REQ-013 Port: resp_rd  out  5  destination register (0 for stores and errors).
REQ-014 Port: resp_err  out  1  misaligned or illegal funct3; no memory access performed.
REQ-015 Port: mem_req, mem_we  out  1, 1  memory request and write enable.
REQ-016 Port: mem_addr  out  32  word-aligned address, req_addr with [1:0] forced to 00.
REQ-017 Port: mem_wdata, mem_be  out  32, 4  lane-shifted store data and byte enables.
REQ-018 Port: mem_ack, mem_rdata  in  1, 32  completion strobe and read word (valid with mem_ack).

Function
REQ-019 The FSM SHALL have the states IDLE, MEM and RESP; all outputs SHALL be registered.
REQ-020 req_ready SHALL be 1 only in IDLE; the op SHALL be accepted when req_valid and req_ready are both 1, and all request fields SHALL be captured in that cycle.
REQ-021 The op SHALL be illegal when funct3[1:0] = 11, when the op is a store with funct3[2] = 1, or when it is a load with funct3 = 110.
REQ-022 The op SHALL be misaligned for HALF_WORD with addr[0] = 1, and for WORD with addr[1:0] != 00.
REQ-023 An illegal or misaligned op SHALL go IDLE->RESP with resp_err = 1, resp_rdata = 0 and resp_rd = 0; mem_req SHALL never assert for it.
REQ-024 A legal op SHALL go IDLE->MEM, with mem_req = 1 from the cycle after acceptance.
REQ-025 mem_req, mem_we, mem_addr, mem_wdata and mem_be SHALL be held stable until mem_ack is sampled high.
REQ-026 Byte enables SHALL be: BYTE -> 0001 << addr[1:0]; HALF_WORD -> 0011 << addr[1:0]; WORD -> 1111.
REQ-027 Store data SHALL be placed as follows: for BYTE, wdata[7:0] replicated into all 4 lanes; for HALF_WORD, wdata[15:0] replicated into both halves; for WORD, unchanged.
REQ-028 Loads SHALL ignore mem_be (all 1111 permitted) and SHALL drive mem_we = 0.
REQ-029 On mem_ack in MEM, mem_req SHALL drop in the next cycle and the FSM SHALL go to RESP.
REQ-030 For a load, the selected lane (mem_rdata >> 8*addr[1:0]) SHALL be captured and then sign-extended when funct3[2] = 0 or zero-extended when funct3[2] = 1.
REQ-031 A store SHALL complete with resp_rd = 0 and resp_rdata = 0.
REQ-032 The response latency for a legal op SHALL be: accept in cycle N, mem_req in N+1, mem_ack in cycle M ≥ N+1, resp_valid in M+1; an ack in N+1 SHALL give resp_valid in N+2.
REQ-033 The response latency for an error op SHALL be resp_valid in N+1.
REQ-034 In RESP, resp_valid SHALL be held at 1 with stable data until resp_ready = 1; the FSM SHALL then return to IDLE and clear resp_valid next cycle.
REQ-035 A new request SHALL NOT be accepted in the same cycle as the response handshake; the minimum spacing between accepted ops SHALL be 2 cycles for error ops and 3 cycles for legal ops.
REQ-036 mem_ack SHALL be ignored outside MEM.
REQ-037 mem_rdata SHALL be sampled only with mem_ack.

Reset
REQ-038 While rst = 1, the state SHALL be IDLE and the outputs SHALL be: req_ready = 0, resp_valid = 0, resp_err = 0, mem_req = 0, mem_we = 0, mem_be = 0000, and all data and address outputs = 0.
REQ-039 req_ready SHALL assert in the first cycle after rst is released.
REQ-040 Reset mid-operation (in MEM or RESP) SHALL abandon the op: mem_req drops next edge, no response is issued, and a late mem_ack is ignored.

Verification
REQ-041 LB, addr 0x1003, mem_rdata 0x80FF_1234, ack at N+1 -> mem_addr 0x1000, resp_rdata 0xFFFF_FF80, resp_valid at N+2.
REQ-042 LHU, addr 0x2002, mem_rdata 0xBEEF_0000 -> resp_rdata 0x0000_BEEF; LH with the same stimulus -> 0xFFFF_BEEF.
REQ-043 SB, addr 0x3001, wdata 0x1234_56AB -> mem_we 1, mem_be 0010, mem_wdata 0xABAB_ABAB; resp_rd 0.
REQ-044 LW, addr 0x4002 -> no mem_req, resp_err 1 at N+1; funct3 011 -> same response.
REQ-045 Ack delayed 5 cycles with resp_ready held low 3 cycles -> mem outputs stable throughout, resp data stable, req_ready low until the handshake completes.
REQ-046 rst asserted while in MEM, then mem_ack pulsed -> no resp_valid, req_ready = 1 one cycle after rst is released.
